// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte receiver.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable reset level.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 receive-only slave: oversamples the pins in the clk domain and
// assembles MSB-first bytes, strobing each completed byte and frame boundary.
//
// state | meaning
// IDLE  | CS_N inactive (or not yet seen falling); SCLK rises ignored
// SHIFT | inside a frame; each SCLK rise shifts one MOSI bit in
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_err,
    output logic                  busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("spi_byte_rx: SYNC_STAGES must be 2..4");
    end
    if (SYSTEM_CLOCK < 8) begin : g_bad_clk
        $error("spi_byte_rx: SYSTEM_CLOCK too low for any SCLK rate");
    end

    // Synchronizer pipeline fill time after reset; CS edges are masked until it expires
    // so a bus already held low at reset release does not look like a new frame.
    localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES + 1);

    logic sclk_s, mosi_s, cs_s;
    logic sclk_q, cs_q;
    logic [2:0] settle_cnt;
    logic edges_on, rise, cs_fall, cs_rise;

    spi_state_t            state;
    logic [2:0]            bit_cnt;
    logic [SPI_BYTE_W-2:0] shreg;

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            settle_cnt <= SETTLE_INIT;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            if (settle_cnt != 3'd0) begin
                settle_cnt <= settle_cnt - 3'd1;
            end
        end
    end

    assign edges_on = (settle_cnt == 3'd0);
    assign rise     = sclk_s & ~sclk_q;
    assign cs_fall  = edges_on & ~cs_s & cs_q;
    assign cs_rise  = edges_on & cs_s & ~cs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    state       <= SHIFT;
                    bit_cnt     <= 3'd0;
                    shreg       <= '0;
                    frame_start <= 1'b1;
                end
            end else begin
                // CS edge takes priority over a coincident SCLK rise; that bit is dropped.
                if (cs_rise) begin
                    state     <= IDLE;
                    frame_end <= 1'b1;
                    frame_err <= (bit_cnt != 3'd0);
                end else if (rise) begin
                    shreg   <= {shreg[SPI_BYTE_W-3:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= {shreg, mosi_s};
                        rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: doc/spi_byte_rx.md
# spi_byte_rx

SPI mode-0 slave receiver. It oversamples the external SCLK, MOSI and CS_N pins in the system clock domain and assembles bytes MSB-first. Each completed byte is emitted with a one-cycle strobe. It sits directly upstream of the LED activity stretcher and the pixel byte consumer: `rx_valid` feeds the stretcher's `in`, and `rx_data`/`rx_valid` feed the neopixel frame logic.

## Interface
- `SYSTEM_CLOCK`, default 50000000: clk frequency in Hz. Informational only; SCLK must be ≤ SYSTEM_CLOCK/8.
- `SYNC_STAGES`, default 2: synchronizer depth on each pin input. Legal values are 2 to 4.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sclk` input, 1 bit: SPI clock pin, asynchronous to clk.
- `mosi` input, 1 bit: SPI data pin, asynchronous.
- `cs_n` input, 1 bit: SPI chip select pin, active-low, asynchronous.
- `rx_data` output, 8 bits: last completed byte. Holds its value until the next byte completes.
- `rx_valid` output, 1 bit: one-cycle strobe when `rx_data` updates.
- `frame_start` output, 1 bit: one-cycle strobe on synchronized CS_N falling edge.
- `frame_end` output, 1 bit: one-cycle strobe on synchronized CS_N rising edge.
- `frame_err` output, 1 bit: one-cycle strobe when CS_N rises with 1–7 bits pending.
- `busy` output, 1 bit: high while state is SHIFT.

## Operation
- **Synchronization:** each pin passes through `SYNC_STAGES` flops, giving `sclk_s`, `mosi_s` and `cs_s`. One extra flop holds the previous `sclk_s` and `cs_s` for edge detection.
  - `rise` = `sclk_s & ~sclk_q`.
  - `cs_fall` = `~cs_s & cs_q`.
  - `cs_rise` = `cs_s & ~cs_q`.
- **State machine (IDLE, SHIFT):**
  - IDLE → SHIFT on `cs_fall`. Clears `bit_cnt` and the shift register, and pulses `frame_start`.
  - In SHIFT, each `rise` does `shreg <= {shreg[6:0], mosi_s}` and `bit_cnt <= bit_cnt + 1`. `bit_cnt` is 3 bits and wraps 7→0.
  - On the `rise` that takes `bit_cnt` from 7 to 0, the completed byte `{shreg[6:0], mosi_s}` is loaded into `rx_data`, and `rx_valid` pulses on the next cycle. The state remains SHIFT.
  - SHIFT → IDLE on `cs_rise`. This pulses `frame_end`. If `bit_cnt != 0`, it also pulses `frame_err` in the same cycle, and the partial byte is discarded without any `rx_valid`.
- **Ignored events:**
  - `rise` in IDLE is ignored, so no counting and no `rx_valid`.
  - `cs_rise` in IDLE is ignored, so no `frame_end`.
- **Simultaneous events:** `rise` and `cs_rise` in the same cycle: the CS edge wins, the bit is dropped, and `frame_err` follows the pre-edge `bit_cnt`.
- **SCLK falling edges** are ignored. MISO is not driven; this is a receive-only block.
- **Reset:** `rst` forces IDLE, `bit_cnt`=0, `shreg`=0, `rx_data`=8'h00, and all strobes and `busy` to 0. Synchronizer flops reset to `sclk`=0 and `cs_n`=1 (idle bus levels), so releasing reset onto an idle bus produces no spurious edges.
- **Reset mid-byte:** the partial byte is lost. No `frame_end` or `frame_err` is generated. After reset release, if `cs_n` is already low, no `frame_start` is produced, and the block waits for the next CS_N falling edge.

## Timing
- Pin-to-detect latency is `SYNC_STAGES`+1 clk cycles, with ±1 cycle of sampling uncertainty.
- `rx_valid` is high on the clk edge after the cycle in which the 8th `rise` is detected. Total is `SYNC_STAGES`+2 cycles from the SCLK pin edge, which is 4 cycles at the default.
- `rx_data` is stable in the same cycle `rx_valid` is high, and remains so until the next strobe.
- `frame_start`, `frame_end` and `frame_err` are registered, at `SYNC_STAGES`+2 cycles from the CS_N pin edge.
- **Pin timing requirements:**
  - SCLK high and low phases must each be ≥ 4 clk periods.
  - MOSI must be stable from ≥ 1 clk before to ≥ 1 clk after the SCLK rising pin edge. The matched sync depth keeps MOSI and SCLK aligned.
  - CS_N fall to first SCLK rise must be ≥ 4 clk periods.
- Back-to-back bytes are supported with no gap. The minimum `rx_valid` spacing is 8 SCLK periods, which is ≥ 64 clk cycles.

## Structure
- Shared package `spi_pkg`: state typedef `spi_state_t` {IDLE, SHIFT}, and `SPI_BYTE_W` = 8.
- Sub-module `sync_bit`, instantiated three times (for `sclk`, `mosi`, `cs_n`):
  - parameters `STAGES` and `RESET_VAL`;
  - ports `clk`, `rst`, `d`, `q`.
- Edge detection, the FSM, the counter and the shift register live in `spi_byte_rx`.

## Test plan
- **Single byte:** CS_N low, send 8'hA5 at SCLK = clk/8, CS_N high. Expect:
  - `frame_start` ×1;
  - `rx_valid` ×1 with `rx_data`=8'hA5 at 4 cycles after the 8th SCLK rise;
  - `frame_end` ×1;
  - `frame_err` = 0.
- **Streaming:** send 8'h00, 8'hFF, 8'h3C back-to-back in one frame. Expect three `rx_valid` pulses 64 cycles apart, in order, with matching data.
- **Aborted byte:** send 5 bits, then CS_N high. Expect `frame_end` and `frame_err` in the same cycle, no `rx_valid`, and `rx_data` unchanged from its prior value.
- **SCLK toggling with CS_N high:** send 16 edges. Expect no strobes, `busy`=0, and `rx_data` unchanged.
- **Reset mid-byte:** assert `rst` after 3 bits with CS_N held low, release it, then do a full CS_N high/low cycle and send 8'h81. Expect:
  - during `rst`, all outputs are 0;
  - no `frame_start` until the new CS_N fall;
  - then `rx_data`=8'h81.
- **SYNC_STAGES=3:** repeat the single-byte test. Expect `rx_valid` latency of 5 cycles.
